dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port data memory between the two cores of the dual-core RV32 system.
- Each core's load/store stage raises a request when its decoded control asserts MemRead or MemWrite. The arbiter grants one requester at a time (round-robin) and sequences the memory transaction through a request/ready handshake.
- Returns read data plus a one-cycle ack to the granted core, and provides per-core stall so the pipeline holds while waiting.
- Includes a transaction timeout and a saturating contention counter.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, max cycles in BUSY waiting for mem_ready; 0 disables the timeout.
- CW, 16, contention counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- c0_req  in  1  core0 access request, held until c0_ack.
- c0_we  in  1  core0 write enable (1 = store, 0 = load).
- c0_addr  in  AW  core0 byte address.
- c0_wdata  in  DW  core0 store data.
- c0_rdata  out  DW  core0 load data, valid with c0_ack.
- c0_ack  out  1  one-cycle transaction-complete pulse.
- c0_err  out  1  timeout flag, valid with c0_ack.
- c0_stall  out  1  c0_req & ~c0_ack (combinational).
- c1_req, c1_we, c1_addr, c1_wdata, c1_rdata, c1_ack, c1_err, c1_stall: same as core0, for core1.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse from memory.
- contention_cnt  out  CW  saturating count of arbitration decisions where both cores requested.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE; last_grant = 1, so core0 wins the first tie.
  - mem_req, mem_we = 0; mem_addr, mem_wdata = 0.
  - cX_ack, cX_err = 0; cX_rdata = 0.
  - timeout counter = 0; contention_cnt = 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both request: grant ~last_grant and increment contention_cnt, saturating at all-ones.
  - On grant: register the winner's we/addr/wdata into mem_* outputs, set mem_req = 1, update last_grant, go to BUSY.
- BUSY:
  - mem_req and all mem_* fields are held stable.
  - Timeout counter increments each cycle.
  - On mem_ready: capture mem_rdata (0 if the access was a write), drop mem_req, go to RESP with err = 0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without mem_ready: drop mem_req, rdata = 0, err = 1, go to RESP.
  - mem_ready arriving in the timeout cycle counts as success.
- RESP:
  - Assert ack (and err, if set) for exactly one cycle to the granted core only.
  - Clear the timeout counter and return to IDLE.
  - rdata holds its value until the next RESP.
- Latency: request sampled in IDLE at cycle t → mem_req high at t+1.
  - mem_ready at t+1+k → ack at t+2+k.
  - Minimum 2 cycles to ack with a zero-wait memory.
- Requester rule:
  - The core deasserts req, or presents a new request, in the cycle after ack.
  - A new request issued then is eligible in the following IDLE cycle, giving back-to-back throughput of one transaction per 3 cycles plus memory wait.
- Request changes: a non-granted core's request stays pending with its stall high. Changes to the granted core's fields after grant are ignored.
- Spurious mem_ready (IDLE/RESP): ignored, no state change.
- Reset mid-operation: any state → IDLE next edge. In-flight transaction is abandoned, mem_req drops immediately, no ack is issued.
- Fairness: a continuously requesting core never starves the other. With both requesting, grants strictly alternate.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, BUSY, RESP).
  - grant_id_t (1-bit core index).
  - default parameter constants.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id, both_req.
  - The FSM, registers and counters stay in dmem_arbiter.

Test Plan:
- Single load: c0 loads addr 0x100, memory returns 0xDEADBEEF after 3 wait cycles → mem_req high for 4 cycles; c0_ack pulses once with c0_rdata = 0xDEADBEEF, c0_err = 0; c1_ack never asserts.
- Simultaneous requests after reset: c0 store 0x10 ← 0x1234 and c1 load 0x20, both at cycle t, zero-wait memory → c0 granted first (mem_we = 1, mem_addr = 0x10); c1 granted next (mem_addr = 0x20); contention_cnt = 1; c1_stall high until its ack.
- Sustained contention: both cores re-request immediately after each ack for 8 transactions → grant order 0,1,0,1,…; contention_cnt = 8.
- Timeout: TIMEOUT = 4, c1 load, mem_ready never asserted → mem_req drops after 4 BUSY cycles; c1_ack = 1 with c1_err = 1, c1_rdata = 0; the next request is served normally.
- Reset mid-BUSY: assert rst_n = 0 for 1 cycle during BUSY → mem_req = 0 and state = IDLE next edge; no ack; contention_cnt = 0; spurious mem_ready afterwards is ignored.
- Saturation: CW = 2, force 5 contended grants → contention_cnt stops at 3.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the dual-core data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CW      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Core index: 0 = core0, 1 = core1
  typedef logic grant_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the core not granted last time wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_id_t  last_grant,
  output logic       gnt_valid,
  output grant_id_t  gnt_id,
  output logic       both_req
);

  // Pick a winner from the current request pair
  always_comb begin
    gnt_valid = |req;
    both_req  = &req;
    if (both_req) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two cores: round-robin grant,
// request/ready handshake to memory, one-cycle ack back, timeout and a
// saturating contention counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic [DW-1:0] c0_rdata,
  output logic          c0_ack,
  output logic          c0_err,
  output logic          c0_stall,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic [DW-1:0] c1_rdata,
  output logic          c1_ack,
  output logic          c1_err,
  output logic          c1_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [CW-1:0] contention_cnt
);

  // Counter only needs to reach TIMEOUT-1
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state, state_nxt;
  grant_id_t       last_grant;
  logic [TW-1:0]   tcnt;
  logic            resp_err;
  logic            timeout_hit;
  logic [DW-1:0]   rsp_data;

  logic            gnt_valid;
  grant_id_t       gnt_id;
  logic            both_req;

  rr_arb2 u_rr (
    .req        ({c1_req, c0_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .both_req   (both_req)
  );

  // Timeout detection and the data returned to the core on completion
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    rsp_data    = (mem_ready && !mem_we) ? mem_rdata : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = BUSY;
      BUSY:    if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, memory handshake, response capture and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      tcnt           <= '0;
      resp_err       <= 1'b0;
      c0_rdata       <= '0;
      c1_rdata       <= '0;
      contention_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_id;
            mem_req    <= 1'b1;
            mem_we     <= gnt_id ? c1_we    : c0_we;
            mem_addr   <= gnt_id ? c1_addr  : c0_addr;
            mem_wdata  <= gnt_id ? c1_wdata : c0_wdata;
            if (both_req && (contention_cnt != '1)) begin
              contention_cnt <= contention_cnt + 1'b1;
            end
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          // mem_ready wins over a same-cycle timeout
          if (mem_ready || timeout_hit) begin
            mem_req  <= 1'b0;
            resp_err <= !mem_ready;
            if (last_grant) c1_rdata <= rsp_data;
            else            c0_rdata <= rsp_data;
          end
        end
        RESP: begin
          tcnt <= '0;
        end
        default: begin
          tcnt <= '0;
        end
      endcase
    end
  end

  // Ack/err routed to the granted core; stall is purely combinational
  always_comb begin
    c0_ack   = (state == RESP) && (last_grant == 1'b0);
    c1_ack   = (state == RESP) && (last_grant == 1'b1);
    c0_err   = c0_ack & resp_err;
    c1_err   = c1_ack & resp_err;
    c0_stall = c0_req & ~c0_ack;
    c1_stall = c1_req & ~c1_ack;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table for the simultaneous-request
// case plus hand sequences for wait states, timeout, reset and contention.
// Instance a uses TIMEOUT=4, instance b uses CW=2; both share all inputs.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c0_req, c0_we, c1_req, c1_we, mem_ready;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata, mem_rdata;

  logic [31:0] a_c0_rdata, a_c1_rdata, a_mem_addr, a_mem_wdata;
  logic        a_c0_ack, a_c0_err, a_c0_stall, a_c1_ack, a_c1_err, a_c1_stall;
  logic        a_mem_req, a_mem_we;
  logic [15:0] a_cnt;

  logic [31:0] b_c0_rdata, b_c1_rdata, b_mem_addr, b_mem_wdata;
  logic        b_c0_ack, b_c0_err, b_c0_stall, b_c1_ack, b_c1_err, b_c1_stall;
  logic        b_mem_req, b_mem_we;
  logic [1:0]  b_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .CW(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(a_c0_rdata), .c0_ack(a_c0_ack), .c0_err(a_c0_err), .c0_stall(a_c0_stall),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(a_c1_rdata), .c1_ack(a_c1_ack), .c1_err(a_c1_err), .c1_stall(a_c1_stall),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .contention_cnt(a_cnt)
  );

  dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(64), .CW(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(b_c0_rdata), .c0_ack(b_c0_ack), .c0_err(b_c0_err), .c0_stall(b_c0_stall),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(b_c1_rdata), .c1_ack(b_c1_ack), .c1_err(b_c1_err), .c1_stall(b_c1_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .contention_cnt(b_cnt)
  );

  typedef struct {
    logic        c0_req, c0_we;
    logic [31:0] c0_addr, c0_wdata;
    logic        c1_req, c1_we;
    logic [31:0] c1_addr, c1_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mem_req, e_mem_we;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_ack0, e_ack1, e_stall0, e_stall1;
    logic [31:0] e_rd0, e_rd1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(a_mem_req), 0);
    chk("rst_mem_we", 32'(a_mem_we), 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_acks", {a_c0_ack, a_c1_ack, a_c0_err, a_c1_err}, 0);
    chk("rst_c0_rdata", a_c0_rdata, 0);
    chk("rst_c1_rdata", a_c1_rdata, 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_b", {b_mem_req, b_c0_ack, b_c1_ack, b_cnt}, 0);
    rst_n = 1;
  endtask

  initial begin
    int high, acks0, acks1, seen, drop, found, got, exp_id, id, g0, g1;

    rst_n = 0;
    idle_inputs();

    // c0 store 0x10<-0x1234 and c1 load 0x20 together, zero-wait memory;
    // rows 6/7 add a spurious mem_ready in IDLE
    vt[0] = '{1,1,32'h10,32'h1234, 1,0,32'h20,0, 0,0,          0,0,32'h0,32'h0,       0,0,1,1, 0,0,            0};
    vt[1] = '{1,1,32'h10,32'h1234, 1,0,32'h20,0, 1,32'hAAAA,   1,1,32'h10,32'h1234,   0,0,1,1, 0,0,            1};
    vt[2] = '{1,1,32'h10,32'h1234, 1,0,32'h20,0, 0,0,          0,1,32'h10,32'h1234,   1,0,0,1, 0,0,            1};
    vt[3] = '{0,1,32'h10,32'h1234, 1,0,32'h20,0, 0,0,          0,1,32'h10,32'h1234,   0,0,0,1, 0,0,            1};
    vt[4] = '{0,1,32'h10,32'h1234, 1,0,32'h20,0, 1,32'h55667788, 1,0,32'h20,32'h0,    0,0,0,1, 0,0,            1};
    vt[5] = '{0,1,32'h10,32'h1234, 1,0,32'h20,0, 0,0,          0,0,32'h20,32'h0,      0,1,0,0, 0,32'h55667788, 1};
    vt[6] = '{0,0,32'h0,32'h0,     0,0,32'h0,0,  1,32'hFFFFFFFF, 0,0,32'h20,32'h0,    0,0,0,0, 0,32'h55667788, 1};
    vt[7] = '{0,0,32'h0,32'h0,     0,0,32'h0,0,  0,0,          0,0,32'h20,32'h0,      0,0,0,0, 0,32'h55667788, 1};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c0_req = vt[i].c0_req; c0_we = vt[i].c0_we; c0_addr = vt[i].c0_addr; c0_wdata = vt[i].c0_wdata;
      c1_req = vt[i].c1_req; c1_we = vt[i].c1_we; c1_addr = vt[i].c1_addr; c1_wdata = vt[i].c1_wdata;
      mem_ready = vt[i].mem_ready; mem_rdata = vt[i].mem_rdata;
      #1;
      chk($sformatf("v%0d_mem_req", i), 32'(a_mem_req), 32'(vt[i].e_mem_req));
      chk($sformatf("v%0d_mem_we", i), 32'(a_mem_we), 32'(vt[i].e_mem_we));
      chk($sformatf("v%0d_mem_addr", i), a_mem_addr, vt[i].e_mem_addr);
      chk($sformatf("v%0d_mem_wdata", i), a_mem_wdata, vt[i].e_mem_wdata);
      chk($sformatf("v%0d_ack", i), {a_c0_ack, a_c1_ack}, {vt[i].e_ack0, vt[i].e_ack1});
      chk($sformatf("v%0d_err", i), {a_c0_err, a_c1_err}, 0);
      chk($sformatf("v%0d_stall", i), {a_c0_stall, a_c1_stall}, {vt[i].e_stall0, vt[i].e_stall1});
      chk($sformatf("v%0d_c0_rdata", i), a_c0_rdata, vt[i].e_rd0);
      chk($sformatf("v%0d_c1_rdata", i), a_c1_rdata, vt[i].e_rd1);
      chk($sformatf("v%0d_cnt", i), 32'(a_cnt), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_b_req_ack", i), {b_mem_req, b_c0_ack, b_c1_ack}, {vt[i].e_mem_req, vt[i].e_ack0, vt[i].e_ack1});
      chk($sformatf("v%0d_b_cnt", i), 32'(b_cnt), 32'(vt[i].e_cnt[1:0]));
    end

    // Single load with 3 wait states
    @(negedge clk);
    idle_inputs();
    c0_req = 1; c0_addr = 32'h100;
    high = 0; acks0 = 0; acks1 = 0; drop = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (drop != 0) c0_req = 0;
      if (a_mem_req) begin
        high++;
        if (high == 1) begin
          chk("load_mem_addr", a_mem_addr, 32'h100);
          chk("load_mem_we", 32'(a_mem_we), 0);
        end
        mem_ready = (high == 4);
        mem_rdata = (high == 4) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      end else begin
        mem_ready = 0;
      end
      #1;
      if (a_c0_ack) begin
        acks0++;
        chk("load_c0_rdata", a_c0_rdata, 32'hDEADBEEF);
        chk("load_c0_err", 32'(a_c0_err), 0);
        drop = 1;
      end
      if (a_c1_ack) acks1++;
    end
    mem_ready = 0;
    chk("load_mem_req_cycles", 32'(high), 4);
    chk("load_c0_acks", 32'(acks0), 1);
    chk("load_c1_acks", 32'(acks1), 0);
    chk("load_b_c0_rdata", b_c0_rdata, 32'hDEADBEEF);

    // Timeout on instance a: c1 load, memory never answers
    @(negedge clk);
    idle_inputs();
    c1_req = 1; c1_addr = 32'h300;
    high = 0; seen = 0; drop = 0; acks0 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (drop != 0) c1_req = 0;
      if (a_mem_req) high++;
      #1;
      if (a_c1_ack) begin
        seen++;
        chk("to_c1_err", 32'(a_c1_err), 1);
        chk("to_c1_rdata", a_c1_rdata, 0);
        chk("to_busy_cycles", 32'(high), 4);
        drop = 1;
      end
      if (a_c0_ack) acks0++;
    end
    chk("to_ack_count", 32'(seen), 1);
    chk("to_c0_acks", 32'(acks0), 0);

    // Following request served normally
    @(negedge clk);
    c1_req = 1; c1_addr = 32'h304;
    seen = 0; drop = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (drop != 0) c1_req = 0;
      mem_ready = a_mem_req;
      mem_rdata = 32'hCAFEF00D;
      #1;
      if (a_c1_ack) begin
        seen++;
        chk("to_next_rdata", a_c1_rdata, 32'hCAFEF00D);
        chk("to_next_err", 32'(a_c1_err), 0);
        drop = 1;
      end
    end
    chk("to_next_ack_count", 32'(seen), 1);

    // Reset while BUSY
    do_reset();
    c0_req = 1; c0_addr = 32'h400;
    c1_req = 1; c1_addr = 32'h800;
    found = 0;
    for (int cyc = 0; cyc < 6 && found == 0; cyc++) begin
      @(negedge clk);
      #1;
      if (a_mem_req) found = 1;
    end
    chk("rb_busy_reached", 32'(found), 1);
    chk("rb_cnt_before", 32'(a_cnt), 1);
    @(negedge clk);
    rst_n = 0; c0_req = 0; c1_req = 0;
    @(negedge clk);
    #1;
    chk("rb_mem_req", {a_mem_req, b_mem_req}, 0);
    chk("rb_acks", {a_c0_ack, a_c1_ack}, 0);
    chk("rb_cnt", 32'(a_cnt), 0);
    rst_n = 1;
    acks0 = 0; high = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'h12345678;
      #1;
      if (a_mem_req) high++;
      if (a_c0_ack || a_c1_ack) acks0++;
    end
    mem_ready = 0;
    chk("rb_spurious_req", 32'(high), 0);
    chk("rb_spurious_ack", 32'(acks0), 0);
    chk("rb_c0_rdata", a_c0_rdata, 0);
    c0_req = 1; c1_req = 1;
    found = 0;
    for (int cyc = 0; cyc < 6 && found == 0; cyc++) begin
      @(negedge clk);
      #1;
      if (a_mem_req) found = 1;
    end
    chk("rb_regrant_seen", 32'(found), 1);
    chk("rb_regrant_c0_first", a_mem_addr, 32'h400);

    // Sustained contention: 8 back-to-back contended grants, zero-wait memory
    do_reset();
    c0_req = 1; c0_addr = 32'h1000;
    c1_req = 1; c1_addr = 32'h2000;
    high = 0; got = 0; exp_id = 0; g0 = 0; g1 = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      if (a_mem_req) begin
        high++;
        if (high == 1) begin
          id = (a_mem_addr == 32'h2000) ? 1 : 0;
          got++;
          chk($sformatf("cont_order_%0d", got), 32'(id), 32'(exp_id));
          chk($sformatf("cont_cnt_%0d", got), 32'(a_cnt), 32'(got));
          chk($sformatf("cont_sat_%0d", got), 32'(b_cnt), 32'((got > 3) ? 3 : got));
          exp_id = 1 - exp_id;
        end
        mem_ready = 1;
      end else begin
        high = 0;
        mem_ready = 0;
      end
      #1;
      if (a_c0_ack) g0++;
      if (a_c1_ack) g1++;
    end
    chk("cont_grants", 32'(got), 8);
    found = 0;
    for (int cyc = 0; cyc < 6 && found == 0; cyc++) begin
      @(negedge clk);
      mem_ready = a_mem_req;
      #1;
      if (a_c0_ack) g0++;
      if (a_c1_ack) begin g1++; found = 1; end
    end
    @(negedge clk);
    idle_inputs();
    chk("cont_final_ack_seen", 32'(found), 1);
    chk("cont_c0_acks", 32'(g0), 4);
    chk("cont_c1_acks", 32'(g1), 4);
    chk("cont_cnt_final", 32'(a_cnt), 8);
    chk("cont_sat_final", 32'(b_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
